// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL opcodes, default widths, channel structs and slot state
package tlul_pkg;
  localparam int TLUL_AW = 32;
  localparam int TLUL_DW = 32;
  localparam int TLUL_AIW = 8;
  localparam int TLUL_DIW = 1;
  localparam int TLUL_DBW = TLUL_DW >> 3;
  localparam int TLUL_SZW = $clog2($clog2(TLUL_DBW) + 1);
  typedef enum logic [2:0] {
    PutFullData = 3'd0,
    PutPartialData = 3'd1,
    Get = 3'd4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;
  typedef enum logic {
    EMPTY = 1'b0,
    FULL = 1'b1
  } slot_e;
  typedef struct packed {
    tl_a_op_e opcode;
    logic [2:0] param;
    logic [TLUL_SZW-1:0] size;
    logic [TLUL_AIW-1:0] source;
    logic [TLUL_AW-1:0] address;
    logic [TLUL_DBW-1:0] mask;
    logic [TLUL_DW-1:0] data;
  } tl_a_t;
  typedef struct packed {
    tl_d_op_e opcode;
    logic [2:0] param;
    logic [TLUL_SZW-1:0] size;
    logic [TLUL_AIW-1:0] source;
    logic [TLUL_DIW-1:0] sink;
    logic [TLUL_DW-1:0] data;
    logic error;
  } tl_d_t;
endpackage

// File: rtl/tlul_req_check.sv
// tlul_req_check: combinational legality check of an A-channel request (built only with TLUL_RESP_ERR_EN)
`ifdef TLUL_RESP_ERR_EN
module tlul_req_check
  import tlul_pkg::*;
#(
  parameter int TL_AW = TLUL_AW,
  parameter int TL_DBW = TLUL_DBW,
  parameter int TL_SZW = TLUL_SZW,
  parameter int DEPTH = 256
) (
  input  logic [2:0]        opcode,
  input  logic [TL_SZW-1:0] size,
  input  logic [TL_AW-1:0]  address,
  input  logic [TL_DBW-1:0] mask,
  output logic              err
);
  localparam int LG = $clog2(TL_DBW);
  localparam int IW = $clog2(DEPTH);
  logic [LG-1:0] off;
  logic [LG-1:0] align;
  logic [TL_DBW-1:0] full_mask;
  logic bad_op, bad_size, misaligned, out_of_range, bad_full_mask;
  assign off = address[LG-1:0];
  assign align = LG'((1 << size) - 1);
  assign full_mask = TL_DBW'((1 << (1 << size)) - 1) << off;
  assign bad_op = !(opcode == PutFullData || opcode == PutPartialData || opcode == Get);
  assign bad_size = size > TL_SZW'(LG);
  assign misaligned = |(off & align);
  assign out_of_range = |address[TL_AW-1:LG+IW];
  assign bad_full_mask = opcode == PutFullData && mask != full_mask;
  assign err = bad_op || bad_size || misaligned || out_of_range || bad_full_mask;
endmodule
`endif

// File: rtl/tlul_mem_responder.sv
// tlul_mem_responder: TL-UL slave backed by a word memory, one-deep response slot; error checks under TLUL_RESP_ERR_EN
module tlul_mem_responder
  import tlul_pkg::*;
#(
  parameter int TL_AW = TLUL_AW,
  parameter int TL_DW = TLUL_DW,
  parameter int TL_AIW = TLUL_AIW,
  parameter int TL_DIW = TLUL_DIW,
  parameter int TL_DBW = TL_DW >> 3,
  parameter int TL_SZW = $clog2($clog2(TL_DBW) + 1),
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [TL_SZW-1:0] a_size,
  input  logic [TL_AIW-1:0] a_source,
  input  logic [TL_AW-1:0]  a_address,
  input  logic [TL_DBW-1:0] a_mask,
  input  logic [TL_DW-1:0]  a_data,
  output logic              a_ready,
  output logic              d_valid,
  output logic [2:0]        d_opcode,
  output logic [2:0]        d_param,
  output logic [TL_SZW-1:0] d_size,
  output logic [TL_AIW-1:0] d_source,
  output logic [TL_DIW-1:0] d_sink,
  output logic [TL_DW-1:0]  d_data,
  output logic              d_error,
  input  logic              d_ready
);
  localparam int LG = $clog2(TL_DBW);
  localparam int IW = $clog2(DEPTH);
  slot_e state, state_nx;
  logic accept, is_get, is_put, err;
  logic [IW-1:0] idx;
  logic [TL_DW-1:0] mem [DEPTH];
  assign a_ready = !rst && (!d_valid || d_ready);
  assign accept = a_valid && a_ready;
  assign idx = a_address[LG +: IW];
  assign is_get = a_opcode == Get;
  assign is_put = a_opcode == PutFullData || a_opcode == PutPartialData;
  assign d_param = '0;
  assign d_sink = '0;
`ifdef TLUL_RESP_ERR_EN
  logic unused;
  assign unused = ^a_param;
  tlul_req_check #(
    .TL_AW(TL_AW),
    .TL_DBW(TL_DBW),
    .TL_SZW(TL_SZW),
    .DEPTH(DEPTH)
  ) u_check (
    .opcode(a_opcode),
    .size(a_size),
    .address(a_address),
    .mask(a_mask),
    .err(err)
  );
`else
  logic unused;
  assign unused = ^{a_param, a_address[TL_AW-1:LG+IW], a_address[LG-1:0]};
  assign err = 1'b0;
`endif
  // slot state register; reset drops any pending response at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else state <= state_nx;
  end
  // a new accept always (re)fills the slot; otherwise a taken response empties it
  always_comb begin
    state_nx = accept ? FULL : (d_ready ? EMPTY : state);
  end
  // response valid straight from the slot state
  always_comb begin
    d_valid = state == FULL;
  end
  // response payload loaded on accept, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_opcode <= '0;
      d_size <= '0;
      d_source <= '0;
      d_data <= '0;
      d_error <= 1'b0;
    end else if (accept) begin
      d_opcode <= is_get ? AccessAckData : AccessAck;
      d_size <= a_size;
      d_source <= a_source;
      d_data <= (is_get && !err) ? mem[idx] : '0;
      d_error <= err;
    end
  end
  // byte-lane writes for accepted legal Puts; contents are never reset
  always_ff @(posedge clk) begin
    if (accept && is_put && !err)
      for (int i = 0; i < TL_DBW; i++)
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
  end
endmodule

// File: tb/tb_tlul_mem_responder.sv
// tb_tlul_mem_responder: directed self-checking bench for tlul_mem_responder (TLUL_RESP_ERR_EN selects the error-build vectors)
module tb_tlul_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic a_valid;
  logic [2:0] a_opcode, a_param;
  logic [1:0] a_size;
  logic [7:0] a_source;
  logic [31:0] a_address;
  logic [3:0] a_mask;
  logic [31:0] a_data;
  logic a_ready;
  logic d_valid;
  logic [2:0] d_opcode, d_param;
  logic [1:0] d_size;
  logic [7:0] d_source;
  logic [0:0] d_sink;
  logic [31:0] d_data;
  logic d_error;
  logic d_ready;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlul_mem_responder dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_ready(a_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
    .d_ready(d_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [7:0] src, input logic [1:0] size);
    a_opcode = op;
    a_address = addr;
    a_mask = mask;
    a_data = data;
    a_source = src;
    a_size = size;
    a_valid = 1'b1;
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, input logic [7:0] src, input logic [1:0] size);
    set_a(op, addr, mask, data, src, size);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    d_ready = 1'b1;
    a_param = 3'd0;
    set_a(3'd4, 32'h10, 4'hF, 32'h0, 8'h1, 2'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", a_ready, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_d_fields", {d_opcode, d_param, d_size, d_source, d_sink, d_error}, 0);
    check("rst_d_data", d_data, 0);
    rst = 1'b0;
    a_valid = 1'b0;

    req(3'd0, 32'h10, 4'hF, 32'hDEADBEEF, 8'h5, 2'd2);
    @(negedge clk);
    check("putfull_valid", d_valid, 1);
    check("putfull_opcode", d_opcode, 0);
    check("putfull_source", d_source, 8'h5);
    check("putfull_error", d_error, 0);
    check("putfull_size", d_size, 2);
    req(3'd4, 32'h10, 4'hF, 32'h0, 8'h6, 2'd2);
    @(negedge clk);
    check("get1_opcode", d_opcode, 1);
    check("get1_data", d_data, 32'hDEADBEEF);
    check("get1_source", d_source, 8'h6);
    req(3'd1, 32'h10, 4'h3, 32'h00001234, 8'h1, 2'd1);
    @(negedge clk);
    check("putpart_opcode", d_opcode, 0);
    req(3'd4, 32'h10, 4'hF, 32'h0, 8'h2, 2'd2);
    @(negedge clk);
    check("get2_data", d_data, 32'hDEAD1234);
    check("get2_param_sink", {d_param, d_sink}, 0);

    req(3'd0, 32'h20, 4'hF, 32'hCAFEF00D, 8'h2, 2'd2);
    @(negedge clk);
    check("put20_opcode", d_opcode, 0);
    @(posedge clk);
    #1;
    d_ready = 1'b0;
    req(3'd4, 32'h20, 4'hF, 32'h0, 8'h7, 2'd2);
    set_a(3'd4, 32'h10, 4'hF, 32'h0, 8'h9, 2'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_a_ready", a_ready, 0);
      check("stall_d_valid", d_valid, 1);
      check("stall_d_hold", {d_opcode, d_source, d_data}, {3'd1, 8'h7, 32'hCAFEF00D});
    end
    d_ready = 1'b1;
    #1;
    check("release_a_ready", a_ready, 1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    @(negedge clk);
    check("release_resp", {d_valid, d_source, d_data}, {1'b1, 8'h9, 32'hDEAD1234});
    @(posedge clk);
    #1;
    check("release_drained", d_valid, 0);

    for (int i = 0; i < 8; i++) begin
      set_a(3'd0, 32'h40 + 32'(4 * i), 4'hF, 32'h10000000 + 32'(i) * 32'h01010101, 8'(i), 2'd2);
      @(posedge clk);
      @(negedge clk);
      check("stream_put_valid", d_valid, 1);
    end
    for (int i = 0; i < 8; i++) begin
      set_a(3'd4, 32'h40 + 32'(4 * i), 4'hF, 32'h0, 8'(8'h20 + i), 2'd2);
      @(posedge clk);
      @(negedge clk);
      check("stream_get", {d_valid, d_source, d_data},
            {1'b1, 8'(8'h20 + i), 32'h10000000 + 32'(i) * 32'h01010101});
    end
    a_valid = 1'b0;
    @(negedge clk);
    check("stream_drained", d_valid, 0);

`ifdef TLUL_RESP_ERR_EN
    req(3'd4, 32'h400, 4'hF, 32'h0, 8'h3, 2'd2);
    @(negedge clk);
    check("err_range", {d_opcode, d_error, d_data}, {3'd1, 1'b1, 32'h0});
    req(3'd2, 32'h10, 4'hF, 32'h0, 8'h3, 2'd2);
    @(negedge clk);
    check("err_opcode", {d_opcode, d_error}, {3'd0, 1'b1});
    req(3'd4, 32'h2, 4'hF, 32'h0, 8'h3, 2'd2);
    @(negedge clk);
    check("err_align", {d_error, d_data}, {1'b1, 32'h0});
    req(3'd0, 32'h10, 4'h3, 32'h55555555, 8'h3, 2'd2);
    @(negedge clk);
    check("err_fullmask", d_error, 1);
    req(3'd4, 32'h10, 4'hF, 32'h0, 8'h3, 2'd2);
    @(negedge clk);
    check("err_nowrite", {d_error, d_data}, {1'b0, 32'hDEAD1234});
`else
    req(3'd0, 32'h400, 4'hF, 32'hA5A5A5A5, 8'h3, 2'd2);
    @(negedge clk);
    check("alias_put_error", d_error, 0);
    req(3'd4, 32'h0, 4'hF, 32'h0, 8'h3, 2'd2);
    @(negedge clk);
    check("alias_get", {d_error, d_data}, {1'b0, 32'hA5A5A5A5});
`endif

    @(posedge clk);
    #1;
    d_ready = 1'b0;
    req(3'd4, 32'h20, 4'hF, 32'h0, 8'h4, 2'd2);
    @(negedge clk);
    check("pre_rst_valid", d_valid, 1);
    set_a(3'd0, 32'h10, 4'hF, 32'h11111111, 8'h4, 2'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_d_valid", d_valid, 0);
    check("mid_rst_a_ready", a_ready, 0);
    check("mid_rst_d_data", d_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_valid = 1'b0;
    d_ready = 1'b1;
    req(3'd4, 32'h10, 4'hF, 32'h0, 8'h8, 2'd2);
    @(negedge clk);
    check("post_rst_get", {d_valid, d_source, d_data}, {1'b1, 8'h8, 32'hDEAD1234});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
